hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It produces the write-enable and flush controls for the PC, the IF/ID register, the ID/EX register and the EX/MEM register. It resolves load-use stalls, taken-branch squashes and data-memory wait freezes through a 4-state FSM. It also keeps saturating stall and flush counters for performance reporting.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/sat_counter.sv | 35 +++
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   state_t    : FSM state encoding (also driven out on the controller's state port)
//   FCNT_W     : width of the post-branch flush down-counter (FLUSH_CYCLES up to 15)
//   NOP_INSTR  : instruction the pipeline registers load when flushed (addi x0,x0,0)
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  localparam int          FCNT_W    = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones.
//   clock : rising-edge clock
//   reset : synchronous active-high clear
//   inc   : count this cycle
//   count : current value
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the 5-stage RISC-V pipeline.
//   Inputs : ID source registers and their use flags, EX destination/load flag,
//            EX taken-branch strobe, data-memory busy.
//   Outputs: PC / IF/ID / EX/MEM write enables, IF/ID and ID/EX flushes
//            (combinational from registered state + current inputs), the FSM
//            state, and saturating stall / flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  state_t            state_q, state_d;
  state_t            ret_q, ret_d;
  state_t            eff_state;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              load_use;

  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    state_d     = state_q;
    ret_d       = ret_q;
    fcnt_d      = fcnt_q;

    // Leaving MEM_WAIT costs no cycle: behave as the state we froze in.
    eff_state = state_q;
    if ((state_q == MEM_WAIT) && !dmem_busy) begin
      eff_state = ret_q;
    end

    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      state_d     = RUN;
      ret_d       = RUN;
      fcnt_d      = '0;
    end else if (dmem_busy) begin
      // Freeze the whole pipe; fcnt is held so a frozen FLUSH resumes intact.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      exmem_write = 1'b0;
      state_d     = MEM_WAIT;
      if (state_q != MEM_WAIT) begin
        ret_d = state_q;
      end
    end else begin
      case (eff_state)
        RUN, LOAD_STALL: begin
          if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
            end else begin
              state_d = RUN;
            end
          end else if ((eff_state == RUN) && load_use) begin
            // In LOAD_STALL the EX slot holds the inserted bubble, so the
            // stale match must not stall a second time.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            state_d    = LOAD_STALL;
          end else begin
            state_d = RUN;
          end
        end
        FLUSH: begin
          ifid_flush = 1'b1;
          fcnt_d     = fcnt_q - FCNT_W'(1);
          state_d    = (fcnt_q == FCNT_W'(1)) ? RUN : FLUSH;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      ret_q   <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign state = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (!reset && !pc_write),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (!reset && ifid_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_memread, ex_branch_taken, dmem_busy;

  logic       pc_write, ifid_write, ifid_flush, idex_flush, exmem_write;
  logic [1:0] state;
  logic [3:0] stall_count, flush_count;

  logic       pc_write1, ifid_write1, ifid_flush1, idex_flush1, exmem_write1;
  logic [1:0] state1;
  logic [7:0] stall_count1, flush_count1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread),
    .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_write(exmem_write), .state(state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(8)) dut1 (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread),
    .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
    .pc_write(pc_write1), .ifid_write(ifid_write1), .ifid_flush(ifid_flush1),
    .idex_flush(idex_flush1), .exmem_write(exmem_write1), .state(state1),
    .stall_count(stall_count1), .flush_count(flush_count1)
  );

  // Output bundle order: {pc_write, ifid_write, ifid_flush, idex_flush, exmem_write}
  function automatic logic [4:0] outs();
    return {pc_write, ifid_write, ifid_flush, idex_flush, exmem_write};
  endfunction

  function automatic logic [4:0] outs1();
    return {pc_write1, ifid_write1, ifid_flush1, idex_flush1, exmem_write1};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_memread = 1'b0; ex_branch_taken = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    reset = 1'b0;
    #1;
  endtask

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       mr, br, busy;
    logic [4:0] exp_out;
    logic [1:0] exp_st;
  } vec_t;

  vec_t vecs[11];

  initial begin
    reset = 1'b1;
    clear_inputs();

    //            name          rs1    rs2    u1 u2 rd     mr br busy exp_out   next
    vecs[0]  = '{"idle",       5'd0,  5'd0,  0, 0, 5'd0,  0, 0, 0, 5'b11001, 2'd0};
    vecs[1]  = '{"lu_rs1",     5'd5,  5'd0,  1, 0, 5'd5,  1, 0, 0, 5'b00011, 2'd1};
    vecs[2]  = '{"lu_rs2",     5'd3,  5'd7,  1, 1, 5'd7,  1, 0, 0, 5'b00011, 2'd1};
    vecs[3]  = '{"lu_x0",      5'd0,  5'd0,  1, 1, 5'd0,  1, 0, 0, 5'b11001, 2'd0};
    vecs[4]  = '{"lu_nouse",   5'd5,  5'd5,  0, 0, 5'd5,  1, 0, 0, 5'b11001, 2'd0};
    vecs[5]  = '{"lu_noload",  5'd5,  5'd0,  1, 0, 5'd5,  0, 0, 0, 5'b11001, 2'd0};
    vecs[6]  = '{"branch",     5'd0,  5'd0,  0, 0, 5'd0,  0, 1, 0, 5'b11111, 2'd2};
    vecs[7]  = '{"br_lu",      5'd5,  5'd0,  1, 0, 5'd5,  1, 1, 0, 5'b11111, 2'd2};
    vecs[8]  = '{"busy_br_lu", 5'd5,  5'd0,  1, 0, 5'd5,  1, 1, 1, 5'b00000, 2'd3};
    vecs[9]  = '{"busy",       5'd0,  5'd0,  0, 0, 5'd0,  0, 0, 1, 5'b00000, 2'd3};
    vecs[10] = '{"lu_miss",    5'd5,  5'd6,  1, 0, 5'd6,  1, 0, 0, 5'b11001, 2'd0};

    // Reset values while reset is held.
    step();
    chk("rst_outs", 32'(outs()), 32'(5'b00110));
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_stall_cnt", 32'(stall_count), 32'd0);
    chk("rst_flush_cnt", 32'(flush_count), 32'd0);

    // Table: each vector applied from a fresh RUN state.
    for (int i = 0; i < 11; i++) begin
      do_reset();
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
      ex_rd = vecs[i].rd; ex_memread = vecs[i].mr;
      ex_branch_taken = vecs[i].br; dmem_busy = vecs[i].busy;
      #1;
      chk({vecs[i].name, "_outs"}, 32'(outs()), 32'(vecs[i].exp_out));
      step();
      chk({vecs[i].name, "_next"}, 32'(state), 32'(vecs[i].exp_st));
    end

    // Load-use: one stall, then LOAD_STALL masks the stale match.
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    #1;
    chk("lu_c0_outs", 32'(outs()), 32'(5'b00011));
    step();
    chk("lu_c1_state", 32'(state), 32'd1);
    chk("lu_c1_outs", 32'(outs()), 32'(5'b11001));
    chk("lu_stall_cnt", 32'(stall_count), 32'd1);
    step();
    chk("lu_c2_state", 32'(state), 32'd0);
    chk("lu_c2_stall_cnt", 32'(stall_count), 32'd1);

    // Branch, FLUSH_CYCLES=2 on dut and 1 on dut1.
    do_reset();
    ex_branch_taken = 1'b1;
    #1;
    chk("br_c0_outs", 32'(outs()), 32'(5'b11111));
    chk("br1_c0_outs", 32'(outs1()), 32'(5'b11111));
    step();
    ex_branch_taken = 1'b0;
    #1;
    chk("br_c1_state", 32'(state), 32'd2);
    chk("br_c1_outs", 32'(outs()), 32'(5'b11101));
    chk("br1_c1_state", 32'(state1), 32'd0);
    chk("br1_c1_outs", 32'(outs1()), 32'(5'b11001));
    chk("br1_flush_cnt", 32'(flush_count1), 32'd1);
    step();
    chk("br_c2_state", 32'(state), 32'd0);
    chk("br_flush_cnt", 32'(flush_count), 32'd2);

    // Freeze for 3 cycles inside FLUSH; fcnt and flush_count held.
    do_reset();
    ex_branch_taken = 1'b1;
    step();
    ex_branch_taken = 1'b0;
    dmem_busy = 1'b1;
    #1;
    chk("fz_c0_outs", 32'(outs()), 32'(5'b00000));
    step();
    chk("fz_c1_state", 32'(state), 32'd3);
    chk("fz_c1_outs", 32'(outs()), 32'(5'b00000));
    step();
    chk("fz_c2_outs", 32'(outs()), 32'(5'b00000));
    step();
    dmem_busy = 1'b0;
    #1;
    chk("fz_exit_state", 32'(state), 32'd3);
    chk("fz_exit_outs", 32'(outs()), 32'(5'b11101));
    chk("fz_flush_cnt", 32'(flush_count), 32'd1);
    chk("fz_stall_cnt", 32'(stall_count), 32'd3);
    step();
    chk("fz_after_state", 32'(state), 32'd0);
    chk("fz_after_flush_cnt", 32'(flush_count), 32'd2);

    // Branch held through a freeze is taken on the exit cycle.
    do_reset();
    dmem_busy = 1'b1; ex_branch_taken = 1'b1;
    #1;
    chk("rb_busy_outs", 32'(outs()), 32'(5'b00000));
    step();
    dmem_busy = 1'b0;
    #1;
    chk("rb_exit_outs", 32'(outs()), 32'(5'b11111));
    step();
    ex_branch_taken = 1'b0;
    #1;
    chk("rb_state", 32'(state), 32'd2);

    // Reset asserted in MEM_WAIT.
    do_reset();
    dmem_busy = 1'b1;
    step();
    chk("rm_state_mw", 32'(state), 32'd3);
    reset = 1'b1;
    #1;
    chk("rm_forced_outs", 32'(outs()), 32'(5'b00110));
    step();
    chk("rm_state", 32'(state), 32'd0);
    chk("rm_stall_cnt", 32'(stall_count), 32'd0);
    chk("rm_flush_cnt", 32'(flush_count), 32'd0);
    chk("rm_forced_outs2", 32'(outs()), 32'(5'b00110));
    reset = 1'b0; dmem_busy = 1'b0;
    #1;
    chk("rm_release_outs", 32'(outs()), 32'(5'b11001));

    // Saturation: 20 frozen cycles, 4-bit counter stops at 15.
    do_reset();
    dmem_busy = 1'b1;
    repeat (20) step();
    chk("sat_stall_cnt", 32'(stall_count), 32'd15);
    chk("sat_stall_cnt_w8", 32'(stall_count1), 32'd20);
    dmem_busy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
